// File: rtl/spi_slave_cmd_link_if.sv
// spi_slave_cmd_link_if: SPI pins, status input and frame hand-off bundle.
// slave: spi_clk/cs/mosi/status/ack in; spi_miso/data/data_num/dready/overrun/busy out.
interface spi_slave_cmd_link_if #(
  parameter int CMD_BITS   = 41,
  parameter int REPLY_BITS = 6,
  parameter int CNT_W      = 7
);
  logic [REPLY_BITS-1:0] status;
  logic                  spi_clk;
  logic                  spi_cs;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic [CMD_BITS-1:0]   data;
  logic [CNT_W-1:0]      data_num;
  logic                  dready;
  logic                  ack;
  logic                  overrun;
  logic                  busy;

  modport slave (
    input  status, spi_clk, spi_cs, spi_mosi, ack,
    output spi_miso, data, data_num, dready, overrun, busy
  );

  modport master (
    output status, spi_clk, spi_cs, spi_mosi, ack,
    input  spi_miso, data, data_num, dready, overrun, busy
  );
endinterface

// File: rtl/spi_slave_cmd_link.sv
// spi_slave_cmd_link: oversampled SPI slave; write frames out via dready/ack,
// read-opcode frames answered with a status snapshot on miso. Ports: clk, rst (sync, low), bus.
module spi_slave_cmd_link #(
  parameter int CMD_BITS    = 41,
  parameter int REPLY_BITS  = 6,
  parameter int OPCODE_BITS = 4,
  parameter logic [OPCODE_BITS-1:0] READ_OPCODE = 4'b1000,
  parameter int SAMPLE_RISE = 1,
  parameter int LSB_FIRST   = 1,
  parameter int SYNC_STAGES = 3,
  parameter int CNT_W       = 7
) (
  input logic clk,
  input logic rst,
  spi_slave_cmd_link_if.slave bus
);

  localparam int RW = $clog2(REPLY_BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    REPLY,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] clk_sh, cs_sh, mosi_sh, fresh;
  logic clk_f, cs_f, mosi_f;
  logic clk_fd, cs_fd;
  logic armed;

  logic [CMD_BITS-1:0]   shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [REPLY_BITS-1:0] reply_q;
  logic [RW-1:0]         rem;
  logic                  miso;
  logic [CMD_BITS-1:0]   data_q;
  logic [CNT_W-1:0]      num_q;
  logic                  dready_q;
  logic                  overrun_q;
  logic                  busy_q;

  logic clk_rise, clk_fall, cs_rise, cs_fall;
  logic sample_edge, launch_edge;
  logic start, store, snap, launch, commit;
  logic [OPCODE_BITS-1:0] op_next;

  // Levels only change once every stage agrees, so short spikes are held off.
  // fresh marks when cs_sh holds only post-reset samples; a frame is accepted
  // only after cs has then been seen high (armed).
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sh  <= '1;
      cs_sh   <= '1;
      mosi_sh <= '1;
      fresh   <= '0;
      clk_f   <= 1'b1;
      cs_f    <= 1'b1;
      mosi_f  <= 1'b1;
      clk_fd  <= 1'b1;
      cs_fd   <= 1'b1;
      armed   <= 1'b0;
    end else begin
      clk_sh  <= {clk_sh[SYNC_STAGES-2:0], bus.spi_clk};
      cs_sh   <= {cs_sh[SYNC_STAGES-2:0], bus.spi_cs};
      mosi_sh <= {mosi_sh[SYNC_STAGES-2:0], bus.spi_mosi};
      fresh   <= {fresh[SYNC_STAGES-2:0], 1'b1};
      if (&clk_sh) clk_f <= 1'b1;
      else if (~|clk_sh) clk_f <= 1'b0;
      if (&cs_sh) cs_f <= 1'b1;
      else if (~|cs_sh) cs_f <= 1'b0;
      if (&mosi_sh) mosi_f <= 1'b1;
      else if (~|mosi_sh) mosi_f <= 1'b0;
      clk_fd <= clk_f;
      cs_fd  <= cs_f;
      if (&fresh && &cs_sh) armed <= 1'b1;
    end
  end

  assign clk_rise = clk_f & ~clk_fd;
  assign clk_fall = ~clk_f & clk_fd;
  assign cs_rise  = cs_f & ~cs_fd;
  assign cs_fall  = ~cs_f & cs_fd;

  assign sample_edge = (SAMPLE_RISE != 0) ? clk_rise : clk_fall;
  assign launch_edge = (SAMPLE_RISE != 0) ? clk_fall : clk_rise;

  // Opcode as it will look once the current bit is stored.
  assign op_next = (LSB_FIRST != 0)
    ? {mosi_f, shreg[OPCODE_BITS-2:0]}
    : {shreg[OPCODE_BITS-2:0], mosi_f};

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    store   = 1'b0;
    snap    = 1'b0;
    launch  = 1'b0;
    commit  = 1'b0;
    if (cs_rise) begin
      state_d = IDLE;
      commit  = (state_q == RECV) && (bit_cnt != '0);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cs_fall && armed) begin
            state_d = RECV;
            start   = 1'b1;
          end
        end
        RECV: begin
          if (sample_edge) begin
            store = 1'b1;
            if (bit_cnt == CNT_W'(OPCODE_BITS - 1) &&
                op_next == READ_OPCODE) begin
              snap    = 1'b1;
              state_d = REPLY;
            end
          end
        end
        REPLY: begin
          if (launch_edge) begin
            launch = 1'b1;
            if (rem == RW'(1)) state_d = DONE;
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      reply_q   <= '0;
      rem       <= '0;
      miso      <= 1'b0;
      data_q    <= '0;
      num_q     <= '0;
      dready_q  <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      busy_q    <= ~cs_f;
      if (start) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end
      if (store && bit_cnt < CNT_W'(CMD_BITS)) begin
        shreg <= (LSB_FIRST != 0)
          ? (shreg | (CMD_BITS'(mosi_f) << bit_cnt))
          : {shreg[CMD_BITS-2:0], mosi_f};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (snap) begin
        reply_q <= bus.status;
        rem     <= RW'(REPLY_BITS);
      end
      if (launch) begin
        miso    <= (LSB_FIRST != 0) ? reply_q[0] : reply_q[REPLY_BITS-1];
        reply_q <= (LSB_FIRST != 0) ? (reply_q >> 1) : (reply_q << 1);
        rem     <= rem - 1'b1;
      end
      if (cs_rise) miso <= 1'b0;
      // A commit that meets an unacked frame drops the new one.
      if (commit) begin
        if (!dready_q || bus.ack) begin
          data_q   <= shreg;
          num_q    <= bit_cnt;
          dready_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (bus.ack && dready_q) begin
        dready_q <= 1'b0;
      end
    end
  end

  assign bus.spi_miso = miso;
  assign bus.data     = data_q;
  assign bus.data_num = num_q;
  assign bus.dready   = dready_q;
  assign bus.overrun  = overrun_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_spi_slave_cmd_link.sv
// tb_spi_slave_cmd_link: randomized frames on two configurations (LSB/rise
// and MSB/fall) checked against a frame-level model of the link.
module tb_spi_slave_cmd_link;
  localparam int CB = 41;
  localparam int RB = 6;
  localparam int CW = 7;
  localparam int H  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic sclk = 1'b0;
  logic cs = 1'b1;
  logic mosi = 1'b0;
  logic sel = 1'b0;
  logic ack = 1'b0;
  logic [RB-1:0] status = '0;

  spi_slave_cmd_link_if #(.CMD_BITS(CB), .REPLY_BITS(RB), .CNT_W(CW)) b0 ();
  spi_slave_cmd_link_if #(.CMD_BITS(CB), .REPLY_BITS(RB), .CNT_W(CW)) b1 ();

  assign b0.spi_clk  = sclk;
  assign b1.spi_clk  = sclk;
  assign b0.spi_cs   = sel ? 1'b1 : cs;
  assign b1.spi_cs   = sel ? cs : 1'b1;
  assign b0.spi_mosi = mosi;
  assign b1.spi_mosi = mosi;
  assign b0.status   = status;
  assign b1.status   = status;
  assign b0.ack      = ack & ~sel;
  assign b1.ack      = ack & sel;

  spi_slave_cmd_link u0 (.clk(clk), .rst(rst), .bus(b0.slave));

  spi_slave_cmd_link #(.SAMPLE_RISE(0), .LSB_FIRST(0)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );

  logic [CB-1:0] o_data;
  logic [CW-1:0] o_num;
  logic o_dready, o_miso, o_busy;
  assign o_data   = sel ? b1.data : b0.data;
  assign o_num    = sel ? b1.data_num : b0.data_num;
  assign o_dready = sel ? b1.dready : b0.dready;
  assign o_miso   = sel ? b1.spi_miso : b0.spi_miso;
  assign o_busy   = sel ? b1.busy : b0.busy;

  int ov0 = 0;
  int ov1 = 0;
  always @(posedge clk) begin
    if (b0.overrun) ov0 <= ov0 + 1;
    if (b1.overrun) ov1 <= ov1 + 1;
  end
  int o_ov;
  assign o_ov = sel ? ov1 : ov0;

  logic [CB-1:0] m_data[2];
  int m_num[2];
  bit m_dr[2];
  int m_ov[2];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [CB-1:0] exp_word(input logic [63:0] wb,
                                             input int n, input bit lsb);
    logic [CB-1:0] d;
    int m;
    d = '0;
    m = (n < CB) ? n : CB;
    for (int k = 0; k < m; k++) begin
      if (lsb) d[k] = wb[k];
      else d = {d[CB-2:0], wb[k]};
    end
    return d;
  endfunction

  function automatic bit is_read(input logic [63:0] wb, input int n,
                                 input bit lsb);
    logic [3:0] op;
    if (n < 4) return 1'b0;
    op = lsb ? wb[3:0] : {wb[0], wb[1], wb[2], wb[3]};
    return op == 4'b1000;
  endfunction

  task automatic model_frame(input int s, input logic [63:0] wb,
                             input int n, input bit lsb);
    if (n == 0 || is_read(wb, n, lsb)) return;
    if (!m_dr[s]) begin
      m_data[s] = exp_word(wb, n, lsb);
      m_num[s]  = (n < CB) ? n : CB;
      m_dr[s]   = 1'b1;
    end else begin
      m_ov[s]++;
    end
  endtask

  task automatic spi_bit(input bit b, input bit glitch, output logic m);
    logic lv;
    lv = sel;
    @(negedge clk);
    sclk = lv;
    mosi = b;
    if (glitch) begin
      repeat (3) @(negedge clk);
      sclk = ~lv;
      @(negedge clk);
      sclk = lv;
      repeat (2) @(negedge clk);
      cs = 1'b1;
      @(negedge clk);
      cs = 1'b0;
      @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
    m = o_miso;
    sclk = ~lv;
    repeat (H - 1) @(negedge clk);
  endtask

  task automatic spi_frame(input logic [63:0] wb, input int n,
                           input int glitch_at, output logic [63:0] mb);
    logic m;
    @(negedge clk);
    sclk = sel;
    cs = 1'b1;
    repeat (H) @(negedge clk);
    cs = 1'b0;
    repeat (H) @(negedge clk);
    mb = '0;
    for (int k = 0; k < n; k++) begin
      spi_bit(wb[k], k == glitch_at, m);
      mb[k] = m;
    end
    @(negedge clk);
    sclk = sel;
    repeat (H) @(negedge clk);
    cs = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    m_dr[sel] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp += 7;
    if (b0.dready !== 1'b0) begin
      n_bad++; $display("FAIL rst_dready: got %b want 0", b0.dready);
    end
    if (b0.data !== '0) begin
      n_bad++; $display("FAIL rst_data: got %h want 0", b0.data);
    end
    if (b0.data_num !== '0) begin
      n_bad++; $display("FAIL rst_num: got %0d want 0", b0.data_num);
    end
    if (b0.overrun !== 1'b0) begin
      n_bad++; $display("FAIL rst_overrun: got %b want 0", b0.overrun);
    end
    if (b0.busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_busy: got %b want 0", b0.busy);
    end
    if (b0.spi_miso !== 1'b0) begin
      n_bad++; $display("FAIL rst_miso: got %b want 0", b0.spi_miso);
    end
    if (b1.dready !== 1'b0) begin
      n_bad++; $display("FAIL rst_dready1: got %b want 0", b1.dready);
    end
    rst = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic test_write_41();
    logic [63:0] wb, mb;
    sel = 1'b0;
    wb = 64'h1_2345_6789A;
    spi_frame(wb, 41, -1, mb);
    model_frame(0, wb, 41, 1'b1);
    n_cmp += 4;
    if (o_dready !== m_dr[0]) begin
      n_bad++; $display("FAIL t1_dready: got %b want %b", o_dready, m_dr[0]);
    end
    if (o_data !== m_data[0]) begin
      n_bad++; $display("FAIL t1_data: got %h want %h", o_data, m_data[0]);
    end
    if (o_num !== CW'(m_num[0])) begin
      n_bad++; $display("FAIL t1_num: got %0d want %0d", o_num, m_num[0]);
    end
    if (o_ov !== m_ov[0]) begin
      n_bad++; $display("FAIL t1_ov: got %0d want %0d", o_ov, m_ov[0]);
    end
    do_ack();
    n_cmp += 2;
    if (o_dready !== 1'b0) begin
      n_bad++; $display("FAIL t1_ack: got %b want 0", o_dready);
    end
    if (o_data !== m_data[0]) begin
      n_bad++; $display("FAIL t1_hold: got %h want %h", o_data, m_data[0]);
    end
  endtask

  task automatic test_random_writes();
    logic [63:0] wb, mb;
    int n;
    sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n = (i == 4) ? 50 : int'($urandom_range(1, CB));
      wb = {$urandom, $urandom};
      if (is_read(wb, n, 1'b1)) wb[3] = 1'b0;
      spi_frame(wb, n, -1, mb);
      model_frame(0, wb, n, 1'b1);
      n_cmp += 3;
      if (o_dready !== m_dr[0]) begin
        n_bad++; $display("FAIL rw_dready[%0d]: got %b want %b", i, o_dready, m_dr[0]);
      end
      if (o_data !== m_data[0]) begin
        n_bad++; $display("FAIL rw_data[%0d]: got %h want %h", i, o_data, m_data[0]);
      end
      if (o_num !== CW'(m_num[0])) begin
        n_bad++; $display("FAIL rw_num[%0d]: got %0d want %0d", i, o_num, m_num[0]);
      end
      do_ack();
    end
  endtask

  task automatic test_read();
    logic [63:0] wb, mb;
    logic [RB-1:0] got;
    sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      status = (i == 0) ? 6'b101101 : RB'($urandom);
      wb = {$urandom, $urandom};
      wb[3:0] = 4'b1000;
      spi_frame(wb, 10, -1, mb);
      got = mb[9:4];
      n_cmp += 3;
      if (got !== status) begin
        n_bad++; $display("FAIL rd_reply[%0d]: got %b want %b", i, got, status);
      end
      if (o_dready !== m_dr[0]) begin
        n_bad++; $display("FAIL rd_dready[%0d]: got %b want %b", i, o_dready, m_dr[0]);
      end
      if (o_miso !== 1'b0) begin
        n_bad++; $display("FAIL rd_miso_idle[%0d]: got %b want 0", i, o_miso);
      end
    end
  endtask

  task automatic test_overrun();
    logic [63:0] mb;
    sel = 1'b0;
    spi_frame(64'hA5, 8, -1, mb);
    model_frame(0, 64'hA5, 8, 1'b1);
    spi_frame(64'h3C, 8, -1, mb);
    model_frame(0, 64'h3C, 8, 1'b1);
    n_cmp += 3;
    if (o_data !== m_data[0]) begin
      n_bad++; $display("FAIL ov_data: got %h want %h", o_data, m_data[0]);
    end
    if (o_dready !== m_dr[0]) begin
      n_bad++; $display("FAIL ov_dready: got %b want %b", o_dready, m_dr[0]);
    end
    if (o_ov !== m_ov[0]) begin
      n_bad++; $display("FAIL ov_pulses: got %0d want %0d", o_ov, m_ov[0]);
    end
    do_ack();
    spi_frame(64'h3C, 8, -1, mb);
    model_frame(0, 64'h3C, 8, 1'b1);
    n_cmp += 3;
    if (o_data !== m_data[0]) begin
      n_bad++; $display("FAIL ov_reload: got %h want %h", o_data, m_data[0]);
    end
    if (o_dready !== m_dr[0]) begin
      n_bad++; $display("FAIL ov_reload_dr: got %b want %b", o_dready, m_dr[0]);
    end
    if (o_ov !== m_ov[0]) begin
      n_bad++; $display("FAIL ov_extra: got %0d want %0d", o_ov, m_ov[0]);
    end
    do_ack();
  endtask

  task automatic test_glitch();
    logic [63:0] wb, mb;
    sel = 1'b0;
    wb = {$urandom, $urandom};
    if (is_read(wb, 16, 1'b1)) wb[3] = 1'b0;
    spi_frame(wb, 16, 8, mb);
    model_frame(0, wb, 16, 1'b1);
    n_cmp += 3;
    if (o_num !== CW'(m_num[0])) begin
      n_bad++; $display("FAIL gl_num: got %0d want %0d", o_num, m_num[0]);
    end
    if (o_data !== m_data[0]) begin
      n_bad++; $display("FAIL gl_data: got %h want %h", o_data, m_data[0]);
    end
    if (o_ov !== m_ov[0]) begin
      n_bad++; $display("FAIL gl_ov: got %0d want %0d", o_ov, m_ov[0]);
    end
    do_ack();
  endtask

  task automatic test_reset_mid();
    logic [63:0] mb;
    logic m;
    sel = 1'b0;
    @(negedge clk);
    sclk = 1'b0;
    cs = 1'b1;
    repeat (H) @(negedge clk);
    cs = 1'b0;
    repeat (H) @(negedge clk);
    for (int k = 0; k < 10; k++) spi_bit(1'($urandom), 1'b0, m);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      m_dr[s] = 1'b0;
      m_data[s] = '0;
      m_num[s] = 0;
    end
    repeat (3 * H) @(negedge clk);
    n_cmp += 3;
    if (o_dready !== 1'b0) begin
      n_bad++; $display("FAIL rm_dready: got %b want 0", o_dready);
    end
    if (o_data !== '0) begin
      n_bad++; $display("FAIL rm_data: got %h want 0", o_data);
    end
    if (o_busy !== 1'b1) begin
      n_bad++; $display("FAIL rm_busy: got %b want 1", o_busy);
    end
    spi_frame(64'b10110, 5, -1, mb);
    model_frame(0, 64'b10110, 5, 1'b1);
    n_cmp += 3;
    if (o_data !== m_data[0]) begin
      n_bad++; $display("FAIL rm_frame: got %h want %h", o_data, m_data[0]);
    end
    if (o_num !== CW'(m_num[0])) begin
      n_bad++; $display("FAIL rm_num: got %0d want %0d", o_num, m_num[0]);
    end
    if (o_dready !== m_dr[0]) begin
      n_bad++; $display("FAIL rm_dr: got %b want %b", o_dready, m_dr[0]);
    end
    do_ack();
  endtask

  task automatic test_msb_fall();
    logic [63:0] wb, mb;
    logic [11:0] v;
    logic [RB-1:0] got;
    sel = 1'b1;
    v = 12'hABC;
    wb = '0;
    for (int k = 0; k < 12; k++) wb[k] = v[11-k];
    spi_frame(wb, 12, -1, mb);
    model_frame(1, wb, 12, 1'b0);
    n_cmp += 3;
    if (o_data !== m_data[1]) begin
      n_bad++; $display("FAIL t6_data: got %h want %h", o_data, m_data[1]);
    end
    if (o_num !== CW'(m_num[1])) begin
      n_bad++; $display("FAIL t6_num: got %0d want %0d", o_num, m_num[1]);
    end
    if (o_dready !== m_dr[1]) begin
      n_bad++; $display("FAIL t6_dready: got %b want %b", o_dready, m_dr[1]);
    end
    do_ack();
    spi_frame('0, 0, -1, mb);
    model_frame(1, '0, 0, 1'b0);
    n_cmp += 2;
    if (o_dready !== m_dr[1]) begin
      n_bad++; $display("FAIL t6_empty: got %b want %b", o_dready, m_dr[1]);
    end
    if (o_ov !== m_ov[1]) begin
      n_bad++; $display("FAIL t6_empty_ov: got %0d want %0d", o_ov, m_ov[1]);
    end
    status = RB'($urandom);
    wb = {$urandom, $urandom};
    wb[3:0] = 4'b0001;
    spi_frame(wb, 10, -1, mb);
    for (int j = 0; j < RB; j++) got[RB-1-j] = mb[4+j];
    n_cmp += 2;
    if (got !== status) begin
      n_bad++; $display("FAIL t6_reply: got %b want %b", got, status);
    end
    if (o_dready !== m_dr[1]) begin
      n_bad++; $display("FAIL t6_rd_dready: got %b want %b", o_dready, m_dr[1]);
    end
    sel = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      m_data[s] = '0;
      m_num[s] = 0;
      m_dr[s] = 1'b0;
      m_ov[s] = 0;
    end
    test_reset();
    test_write_41();
    test_random_writes();
    test_read();
    test_overrun();
    test_glitch();
    test_reset_mid();
    test_msb_fall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
